// File: rtl/jram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jram_arbiter
// Purpose  : Two-port round-robin arbiter and strobe sequencer for the 256x8
//            jRAM block (MAR load via bas/wsa, then write via bis/ws or read
//            via we/bos). Optional macro JRAM_ARB_MAR_CACHE_EN skips the MAR
//            load when the granted address already sits in the RAM's MAR.
// Revision : 1.0  initial release
// ============================================================================
module jram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_done,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_done,
  output logic [DW-1:0] req1_rdata,
  output logic [AW-1:0] bas,
  output logic          wsa,
  output logic [DW-1:0] bis,
  output logic          ws,
  output logic          we,
  input  logic [DW-1:0] bos
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETA   = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]    r_state;
  logic          r_prio;     // port that wins when both request together
  logic          r_port;
  logic          r_write;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_any;
  logic          w_gnt_port;
  logic          w_grant;
  logic [AW-1:0] w_gnt_addr;
  logic          w_hit;

  assign w_any      = req0_valid | req1_valid;
  assign w_gnt_port = (req0_valid & req1_valid) ? r_prio : req1_valid;
  assign w_grant    = (r_state == S_IDLE) & w_any & ~reset;
  assign w_gnt_addr = w_gnt_port ? req1_addr : req0_addr;

`ifdef JRAM_ARB_MAR_CACHE_EN
  logic [AW-1:0] r_mar_addr;
  logic          r_mar_valid;

  assign w_hit = r_mar_valid & (w_gnt_addr == r_mar_addr);

  // Shadow of the RAM's MAR; it changes only when SETA drives wsa.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mar_addr  <= '0;
      r_mar_valid <= 1'b0;
    end else if (r_state == S_SETA) begin
      r_mar_addr  <= r_addr;
      r_mar_valid <= 1'b1;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_prio   <= 1'b0;
      r_port   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_port  <= w_gnt_port;
            r_prio  <= ~w_gnt_port;
            r_write <= w_gnt_port ? req1_write : req0_write;
            r_addr  <= w_gnt_addr;
            r_wdata <= w_gnt_port ? req1_wdata : req0_wdata;
            r_state <= w_hit ? S_ACCESS : S_SETA;
          end
        end
        S_SETA:   r_state <= S_HOLD;
        S_HOLD:   r_state <= S_ACCESS;
        S_ACCESS: begin
          if (!r_write) begin
            if (r_port) r_rdata1 <= bos;
            else        r_rdata0 <= bos;
          end
          r_state <= S_RESP;
        end
        S_RESP:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign req0_ready = w_grant & ~w_gnt_port;
  assign req1_ready = w_grant &  w_gnt_port;
  assign req0_done  = (r_state == S_RESP) & ~r_port & ~reset;
  assign req1_done  = (r_state == S_RESP) &  r_port & ~reset;
  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;

  // Strobes decode straight from state so wsa, ws and we can never overlap.
  assign bas = ((r_state == S_SETA) || (r_state == S_HOLD)) ? r_addr : '0;
  assign wsa = (r_state == S_SETA);
  assign ws  = (r_state == S_ACCESS) &  r_write;
  assign we  = (r_state == S_ACCESS) & ~r_write;
  assign bis = ((r_state == S_ACCESS) && r_write) ? r_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_jram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jram_arbiter
// Purpose  : Directed self-checking bench for jram_arbiter with a jRAM model.
// Revision : 1.0  initial release
// ============================================================================
module tb_jram_arbiter;

`ifdef JRAM_ARB_MAR_CACHE_EN
  localparam int HIT_LAT = 2;
`else
  localparam int HIT_LAT = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_write, req0_ready, req0_done;
  logic [7:0] req0_addr, req0_wdata, req0_rdata;
  logic       req1_valid, req1_write, req1_ready, req1_done;
  logic [7:0] req1_addr, req1_wdata, req1_rdata;
  logic [7:0] bas, bis, bos;
  logic       wsa, ws, we;

  int checks   = 0;
  int failures = 0;
  int wsa_cnt  = 0;
  int ws_cnt   = 0;

  always #5 clk = ~clk;

  jram_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
    .req1_rdata(req1_rdata),
    .bas(bas), .wsa(wsa), .bis(bis), .ws(ws), .we(we), .bos(bos)
  );

  // jRAM model: MAR loads on wsa, writes on ws, read data is combinational.
  logic [7:0] mem [256];
  logic [7:0] mar;
  bit         init_done;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h55;
      init_done <= 1'b1;
    end else begin
      if (wsa) mar <= bas;
      if (ws)  mem[mar] <= bis;
    end
  end
  assign bos = mem[mar];

  always @(posedge clk) begin
    if (wsa) wsa_cnt++;
    if (ws)  ws_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end
  endtask

  function automatic logic ready_of(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic done_of(input int p);
    return (p == 0) ? req0_done : req1_done;
  endfunction

  function automatic logic [7:0] rdata_of(input int p);
    return (p == 0) ? req0_rdata : req1_rdata;
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) tick;
    reset = 1'b0;
    tick;
  endtask

  // One complete request; inputs are scrambled after accept to show they are ignored.
  task automatic access(input int p, input logic w, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output int wait_c);
    set_req(p, 1'b1, w, a, d);
    #1;
    wait_c = 0;
    while (!ready_of(p) && wait_c < 20) begin
      tick; #1; wait_c++;
    end
    lat = -1;
    rd  = 8'h00;
    if (!ready_of(p)) begin
      check("ready_timeout", 32'd0, 32'd1);
      set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
      return;
    end
    tick;
    set_req(p, 1'b0, ~w, ~a, ~d);
    #1;
    lat = 1;
    while (!done_of(p) && lat < 20) begin
      tick; #1; lat++;
    end
    if (!done_of(p)) check("done_timeout", 32'd0, 32'd1);
    rd = rdata_of(p);
    tick;
  endtask

  int         lat, wc, c0, seen_done;
  logic [7:0] rd;
  int         g_port [8], g_cyc [8], d_port [8], d_cyc [8];
  logic [7:0] d_r0 [8], d_r1 [8];
  int         ng, nd;

  initial begin
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) tick;
    #1;
    check("rst_strobes", {req0_ready, req1_ready, req0_done, req1_done, wsa, ws, we}, 32'd0);
    check("rst_buses", {bas, bis, req0_rdata, req1_rdata}, 32'd0);
    reset = 1'b0;
    tick;

    // Port 0 write 0x3C <- 0xA5, cycle by cycle.
    set_req(0, 1'b1, 1'b1, 8'h3C, 8'hA5);
    #1;
    check("w_ready_t", {req0_ready, req1_ready}, 32'b10);
    tick;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    #1;
    check("w_seta", {wsa, ws, we, bas}, {3'b100, 8'h3C});
    tick; #1;
    check("w_hold", {wsa, ws, we, bas}, {3'b000, 8'h3C});
    tick; #1;
    check("w_access", {wsa, ws, we, bis}, {3'b010, 8'hA5});
    tick; #1;
    check("w_done_t4", {req0_done, req1_done, ws}, 32'b100);
    tick; #1;
    check("w_done_once", {req0_done, req1_done}, 32'b00);
    check("w_mem", mem[8'h3C], 32'hA5);
    access(0, 1'b0, 8'h3C, 8'h00, lat, rd, wc);
    check("r3c_data", rd, 32'hA5);
    check("r3c_lat", lat, HIT_LAT);

    // Both ports requesting continuously: grants must alternate 0,1,0,1.
    do_reset;
    for (int k = 0; k < 8; k++) begin
      g_port[k] = -1; g_cyc[k] = -1; d_port[k] = -1; d_cyc[k] = -1;
      d_r0[k] = 8'h00; d_r1[k] = 8'h00;
    end
    ng = 0; nd = 0;
    set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int c = 0; c < 20; c++) begin
      #1;
      if ((req0_ready || req1_ready) && ng < 8) begin
        g_port[ng] = req1_ready ? 1 : 0; g_cyc[ng] = c; ng++;
      end
      if ((req0_done || req1_done) && nd < 8) begin
        d_port[nd] = req1_done ? 1 : 0; d_cyc[nd] = c;
        d_r0[nd] = req0_rdata; d_r1[nd] = req1_rdata; nd++;
      end
      tick;
    end
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    check("rr_ngrants", ng, 4);
    check("rr_ndones", nd, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_gport%0d", k), g_port[k], k % 2);
      check($sformatf("rr_gcyc%0d", k), g_cyc[k], 5 * k);
      check($sformatf("rr_dport%0d", k), d_port[k], k % 2);
      check($sformatf("rr_dcyc%0d", k), d_cyc[k], 5 * k + 4);
      check($sformatf("rr_r0_%0d", k), d_r0[k], 8'h54);
      check($sformatf("rr_r1_%0d", k), d_r1[k], (k == 0) ? 8'h00 : 8'h57);
    end
    tick; tick;

    // Only port 1 requesting: each request granted at once.
    access(1, 1'b0, 8'h05, 8'h00, lat, rd, wc);
    check("p1a_data", rd, 32'h50);
    check("p1a_wait", wc, 0);
    check("p1a_lat", lat, 4);
    access(1, 1'b0, 8'h06, 8'h00, lat, rd, wc);
    check("p1b_data", rd, 32'h53);
    check("p1b_wait", wc, 0);
    access(1, 1'b0, 8'h07, 8'h00, lat, rd, wc);
    check("p1c_data", rd, 32'h52);
    check("p1c_wait", wc, 0);
    set_req(0, 1'b1, 1'b0, 8'h08, 8'h00);
    set_req(1, 1'b1, 1'b0, 8'h09, 8'h00);
    #1;
    check("tie_to_p0", {req0_ready, req1_ready}, 32'b10);
    tick;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
    seen_done = 0;
    for (int c = 0; c < 10 && seen_done == 0; c++) begin
      #1;
      if (req0_done) seen_done = 1;
      else tick;
    end
    check("tie_done", seen_done, 1);
    check("tie_data", req0_rdata, 32'h5D);
    check("tie_p1_untouched", req1_rdata, 32'h52);
    tick;

    // Reset lands during HOLD of a write to 0x10.
    c0 = ws_cnt;
    set_req(0, 1'b1, 1'b1, 8'h10, 8'h99);
    #1;
    check("ab_ready", req0_ready, 1'b1);
    tick;
    set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick;
    reset = 1'b1;
    #1;
    check("ab_in_hold", {wsa, bas}, {1'b0, 8'h10});
    tick; #1;
    check("ab_strobes", {req0_ready, req1_ready, req0_done, req1_done, wsa, ws, we}, 32'd0);
    check("ab_buses", {bas, bis, req0_rdata, req1_rdata}, 32'd0);
    reset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 4; c++) begin
      tick; #1;
      if (req0_done || req1_done) seen_done = 1;
    end
    check("ab_no_done", seen_done, 0);
    check("ab_no_ws", ws_cnt - c0, 0);
    check("ab_mem", mem[8'h10], 32'h45);
    access(0, 1'b0, 8'h10, 8'h00, lat, rd, wc);
    check("ab_read", rd, 32'h45);
    check("ab_read_lat", lat, 4);

    // Top-of-range address on port 1.
    access(1, 1'b1, 8'hFF, 8'h5A, lat, rd, wc);
    check("ff_wlat", lat, 4);
    check("ff_mem", mem[8'hFF], 32'h5A);
    check("ff_w_keeps_rdata", rd, 32'h00);
    access(1, 1'b0, 8'hFF, 8'h00, lat, rd, wc);
    check("ff_read", rd, 32'h5A);
    check("ff_rlat", lat, HIT_LAT);
    access(1, 1'b0, 8'h00, 8'h00, lat, rd, wc);
    check("a00_read", rd, 32'h55);

`ifdef JRAM_ARB_MAR_CACHE_EN
    do_reset;
    c0 = wsa_cnt;
    access(0, 1'b0, 8'h20, 8'h00, lat, rd, wc);
    check("mc_miss_lat", lat, 4);
    check("mc_miss_wsa", wsa_cnt - c0, 1);
    check("mc_miss_data", rd, 32'h75);
    c0 = wsa_cnt;
    access(0, 1'b0, 8'h20, 8'h00, lat, rd, wc);
    check("mc_hit_lat", lat, 2);
    check("mc_hit_wsa", wsa_cnt - c0, 0);
    check("mc_hit_data", rd, 32'h75);
    do_reset;
    c0 = wsa_cnt;
    access(0, 1'b0, 8'h20, 8'h00, lat, rd, wc);
    check("mc_rst_lat", lat, 4);
    check("mc_rst_wsa", wsa_cnt - c0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule
`default_nettype wire

// File: doc/jram_arbiter.md
Name: jram_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer for the 256x8 jRAM block. It shares one RAM between two requesters, such as the fetch and data paths.
- Converts a simple valid/ready request into the RAM's strobe sequence: MAR load via bas/wsa, then data write via bis/ws or read via we/bos.
- Returns a one-cycle done pulse plus registered read data to the winning requester.

Parameters:
- AW, 8, address width; must equal the RAM MAR width.
- DW, 8, data width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  port 0 request pending.
- req0_write  input  1  1 = write, 0 = read; sampled with valid.
- req0_addr  input  AW  port 0 address.
- req0_wdata  input  DW  port 0 write data.
- req0_ready  output  1  request accepted this cycle.
- req0_done  output  1  one-cycle completion pulse.
- req0_rdata  output  DW  read result; valid when done pulses for a read.
- req1_valid, req1_write, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata: same as port 0.
- bas  output  AW  RAM address bus.
- wsa  output  1  MAR set strobe.
- bis  output  DW  RAM write data.
- ws  output  1  RAM write strobe.
- we  output  1  RAM read enable.
- bos  input  DW  RAM read data (combinational from RAM).

Behaviour:
- Reset:
  - State is IDLE. All outputs are 0: ready, done, rdata, bas, wsa, bis, ws, we.
  - Round-robin pointer favours port 0.
  - Reset mid-access aborts the access without any done pulse. If reset lands during ACCESS, ws/we drop the next cycle.
- FSM states: IDLE, SETA, HOLD, ACCESS, RESP.
- IDLE:
  - If any valid is high, grant one port and pulse its ready for one cycle.
  - Latch addr, wdata, write and the port id into internal registers. Go to SETA.
  - Arbitration:
    - Only one valid high: that port wins.
    - Both high: the port not granted last wins.
    - The pointer updates on every grant.
- SETA: bas = latched addr, wsa = 1. Go to HOLD.
- HOLD: bas held at latched addr, wsa = 0, so the MAR closes with a stable address. Go to ACCESS.
- ACCESS:
  - Write: bis = latched wdata, ws = 1.
  - Read: we = 1; bos is registered into that port's rdata at the clock edge ending the cycle.
  - Go to RESP.
- RESP:
  - Granted port's done = 1 for exactly one cycle, for both reads and writes. Go to IDLE.
- Strobe and bus rules:
  - Outside the states above: bas = 0, bis = 0, ws = 0, we = 0, wsa = 0.
  - ws and we are never both high.
  - wsa never overlaps ws or we.
- Timing:
  - Latency: ready at cycle t, done at t+4. One access per 5 cycles.
  - The next grant occurs no earlier than the IDLE cycle after RESP.
- Requester-side rules:
  - Inputs are sampled only in the ready cycle. Changes to addr/wdata after accept have no effect.
  - valid may drop without ready; no request is then recorded.
- Each port's rdata holds its last read value until its next read completes. Writes do not alter rdata.
- Address wraps naturally within AW bits; no range check.

Optional Feature:
- Macro JRAM_ARB_MAR_CACHE_EN.
- When defined:
  - The arbiter keeps mar_addr and mar_valid. mar_valid is cleared on reset and set after any SETA.
  - A granted request whose addr equals mar_addr while mar_valid = 1 skips SETA and HOLD: IDLE -> ACCESS -> RESP. Latency is ready at t, done at t+2.
  - A miss follows the full path and updates mar_addr.
- When not defined: every access runs the full SETA/HOLD sequence and no MAR-tracking registers exist.

Test Plan:
- Reset, then port 0 write addr 0x3C data 0xA5 → ready at t; wsa=1, bas=0x3C at t+1; ws=1, bis=0xA5 at t+3; req0_done at t+4. Then port 0 read 0x3C → req0_rdata=0xA5 with done.
- Both valid continuously, port 0 reads 0x01 and port 1 reads 0x02 → grants alternate 0,1,0,1; each done 5 cycles apart; rdata routed to the correct port only.
- Only port 1 valid for three requests → all three granted to port 1, no starvation stall. A later simultaneous request then goes to port 0.
- Reset asserted during HOLD of a write to 0x10 → no ws pulse, no done; all outputs 0 the next cycle. A subsequent read of 0x10 returns the pre-reset contents.
- Port 1 write 0xFF data 0x5A, then read 0xFF, then read 0x00 → rdata 0x5A, then the RAM contents at 0x00. Address 0xFF decodes correctly (boundary).
- With JRAM_ARB_MAR_CACHE_EN: two back-to-back reads of 0x20 → first done at t+4, second done 2 cycles after its ready with no wsa pulse. After reset the first access to 0x20 pulses wsa again.
